unidade_busca: RTL
==================

Name: unidade_busca

Overview:
- Instruction fetch stage directly upstream of unidade_controle; drives its 3-bit Opcode and consumes its Beqz, Ji and EscPC outputs to select the next PC.
- Owns the PC and the instruction register.
- Fetches 16-bit instructions from instruction memory over a req/ack handshake with variable latency.
- Holds each instruction stable until the datapath signals completion, then updates PC, or halts.

Parameters:
LARG_PC, 8, PC and memory address width in bits (wraps modulo 2^LARG_PC)
LARG_INSTR, 16, instruction width; opcode is always the top 3 bits

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
mem_req  output  1  instruction memory read request
mem_addr  output  LARG_PC  read address, equals pc
mem_ack  input  1  memory returns mem_dado valid this cycle
mem_dado  input  LARG_INSTR  instruction word from memory
instrucao  output  LARG_INSTR  instruction register
Opcode  output  3  instrucao[LARG_INSTR-1 -: 3], combinational, to unidade_controle
instr_valida  output  1  instrucao holds a fetched, not-yet-retired instruction
avanca  input  1  datapath finished current instruction; Beqz/Ji/EscPC/Zero sampled this cycle
Beqz  input  1  from unidade_controle: conditional branch on zero
Ji  input  1  from unidade_controle: unconditional jump
EscPC  input  1  from unidade_controle: 0 = halt after this instruction
Zero  input  1  from datapath: branch source register equals 0
pc  output  LARG_PC  current program counter
parado  output  1  processor halted

Behaviour:
- Reset values (rst high at clock edge, overrides everything):
  - pc=0, instrucao=0, state=BUSCA, instr_valida=0, parado=0.
  - mem_req is registered: 0 in the cycle after reset, 1 from the next cycle (BUSCA entered).
  - mem_ack arriving in a reset cycle is ignored.
- States:
  - BUSCA: mem_req=1, mem_addr=pc, held stable until mem_ack.
    - On an edge with mem_ack=1: instrucao<=mem_dado, mem_req<=0, go to VALIDA.
    - Minimum latency: ack in the first BUSCA cycle gives instr_valida=1 the next cycle.
    - While mem_ack=0: remain in BUSCA indefinitely.
  - VALIDA: instr_valida=1, mem_req=0, instrucao and pc stable.
    - avanca=0: remain.
    - avanca=1 and EscPC=0: go to PARADO, pc unchanged.
    - avanca=1 and EscPC=1: pc<=prox_pc, go to BUSCA.
  - PARADO: parado=1, instr_valida=0, mem_req=0; exited only by rst.
- prox_pc, evaluated in priority order:
  - Ji=1: instrucao[LARG_PC-1:0] (jump target; bits above LARG_PC ignored).
  - Beqz=1 and Zero=1: pc+1+sign_extend(instrucao[6:0]).
  - Otherwise: pc+1.
  - All arithmetic is LARG_PC wide and wraps silently (pc=255 -> 0 with LARG_PC=8).
- Boundary rules:
  - Ji and Beqz both high: Ji wins.
  - Beqz=1 with Zero=0: not taken.
  - mem_ack outside BUSCA is ignored.
  - avanca outside VALIDA is ignored.
  - rst asserted mid-fetch or mid-VALIDA aborts the operation: the next state is BUSCA at pc=0, and the pending fetch is discarded.
- Opcode is purely combinational from instrucao: valid control is produced while instr_valida=1 and is ignored otherwise.

Test Plan:
- Reset, memory acks in the first request cycle, words 0x0000/0x2000/0x4000 at addr 0/1/2, avanca pulsed each VALIDA -> mem_addr 0,1,2; Opcode 000,001,010; each instruction valid 1 cycle after req.
- Memory ack delayed 3 cycles -> mem_req and mem_addr held stable 3 cycles; instrucao unchanged until ack; instr_valida rises the cycle after ack.
- pc=5, instr 0x607E (Beqz, offset -2), Zero=1, avanca -> pc=4; repeat with Zero=0 -> pc=6; pc=0 with offset -2 taken -> pc=255.
- pc=10, instr 0xA033, Ji=1 and Beqz=1 simultaneously -> pc=0x33.
- Instr 0xE000 with EscPC=0 and avanca -> parado=1, mem_req stays 0 for 20 cycles, pc unchanged; rst -> pc=0, fetch resumes.
- rst asserted while in BUSCA with mem_ack=1 in the same cycle -> instrucao=0, instr_valida=0, next request at addr 0.

Source files
------------

// File: rtl/unidade_busca.sv
`default_nettype none
// ============================================================================
// Module  : unidade_busca
// Brief   : Instruction fetch stage: owns PC and instruction register, fetches
//           over a req/ack memory handshake and selects the next PC.
// Revision: 1.0
// ============================================================================
module unidade_busca #(
  parameter int LARG_PC    = 8,
  parameter int LARG_INSTR = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  mem_req,
  output logic [LARG_PC-1:0]    mem_addr,
  input  logic                  mem_ack,
  input  logic [LARG_INSTR-1:0] mem_dado,
  output logic [LARG_INSTR-1:0] instrucao,
  output logic [2:0]            Opcode,
  output logic                  instr_valida,
  input  logic                  avanca,
  input  logic                  Beqz,
  input  logic                  Ji,
  input  logic                  EscPC,
  input  logic                  Zero,
  output logic [LARG_PC-1:0]    pc,
  output logic                  parado
);

  typedef enum logic [1:0] {
    BUSCA  = 2'd0,
    VALIDA = 2'd1,
    PARADO = 2'd2
  } estado_t;

  estado_t               r_estado;
  logic                  r_memReq;
  logic                  r_instrValida;
  logic                  r_parado;
  logic [LARG_PC-1:0]    r_pc;
  logic [LARG_INSTR-1:0] r_instrucao;

  logic [LARG_PC-1:0]    w_desloc;
  logic [LARG_PC-1:0]    w_pcMais1;
  logic [LARG_PC-1:0]    w_proxPc;

  // Branch offset is the low 7 bits, sign-extended to PC width.
  assign w_desloc  = LARG_PC'($signed(r_instrucao[6:0]));
  assign w_pcMais1 = r_pc + LARG_PC'(1);

  always_comb begin
    w_proxPc = w_pcMais1;
    if (Ji)
      w_proxPc = r_instrucao[LARG_PC-1:0];
    else if (Beqz && Zero)
      w_proxPc = w_pcMais1 + w_desloc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_estado      <= BUSCA;
      r_memReq      <= 1'b0;
      r_instrValida <= 1'b0;
      r_parado      <= 1'b0;
      r_pc          <= '0;
      r_instrucao   <= '0;
    end else begin
      case (r_estado)
        BUSCA: begin
          // An ack only completes a fetch that is actually being requested.
          if (r_memReq && mem_ack) begin
            r_instrucao   <= mem_dado;
            r_memReq      <= 1'b0;
            r_instrValida <= 1'b1;
            r_estado      <= VALIDA;
          end else begin
            r_memReq <= 1'b1;
          end
        end
        VALIDA: begin
          if (avanca) begin
            r_instrValida <= 1'b0;
            if (EscPC) begin
              r_pc     <= w_proxPc;
              r_memReq <= 1'b1;
              r_estado <= BUSCA;
            end else begin
              r_parado <= 1'b1;
              r_estado <= PARADO;
            end
          end
        end
        PARADO: begin
          r_memReq      <= 1'b0;
          r_instrValida <= 1'b0;
          r_parado      <= 1'b1;
        end
        default: begin
          r_estado      <= BUSCA;
          r_memReq      <= 1'b0;
          r_instrValida <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req      = r_memReq;
  assign mem_addr     = r_pc;
  assign pc           = r_pc;
  assign instrucao    = r_instrucao;
  assign Opcode       = r_instrucao[LARG_INSTR-1 -: 3];
  assign instr_valida = r_instrValida;
  assign parado       = r_parado;

endmodule
`default_nettype wire
